// File: rtl/effects_controller.sv
// rtl/effects_controller.sv - per-sample sequencer for the two-stage effects pipeline
module effects_controller #(
  parameter int PIPE_LATENCY = 2,
  parameter int GAIN_STEP    = 4,
  parameter int GAIN_INIT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [15:0] sample_in,
  input  logic [10:0] gain_target,
  input  logic        gain_load,
  input  logic        bypass_req,
  input  logic [15:0] pipe_out,
  output logic [15:0] pipe_sample,
  output logic        pipe_en,
  output logic [10:0] gain_value,
  output logic [15:0] out_sample,
  output logic        out_valid,
  output logic        busy,
  output logic        overrun
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_EMIT   = 2'd3;

  localparam logic [10:0] STEP      = 11'(GAIN_STEP);
  localparam logic [10:0] GAIN_RST  = 11'(GAIN_INIT);
  localparam logic [3:0]  LAT_START = 4'(PIPE_LATENCY - 1);

  logic [1:0]  state;
  logic [3:0]  lat_cnt;
  logic [10:0] gain_tgt;
  logic [15:0] dry;
  logic        bypass_active;
  logic [10:0] next_gain;

  // One slew step toward the target, clamped so it lands exactly on the target
  always_comb begin
    next_gain = gain_value;
    if (gain_tgt > gain_value) begin
      if ((gain_tgt - gain_value) > STEP) next_gain = gain_value + STEP;
      else                                next_gain = gain_tgt;
    end else if (gain_tgt < gain_value) begin
      if ((gain_value - gain_tgt) > STEP) next_gain = gain_value - STEP;
      else                                next_gain = gain_tgt;
    end
  end

  assign pipe_en = (state == S_LAUNCH);
  assign busy    = (state != S_IDLE);

  // Host gain target capture; independent of the sample sequence
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            gain_tgt <= GAIN_RST;
    else if (gain_load) gain_tgt <= gain_target;
  end

  // Overrun flag latches any strobe that arrives while a sample is in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          overrun <= 1'b0;
    else if (sample_valid && busy)    overrun <= 1'b1;
  end

  // Sample sequencer: capture, launch, wait out pipeline latency, emit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      lat_cnt       <= 4'd0;
      pipe_sample   <= 16'd0;
      dry           <= 16'd0;
      bypass_active <= 1'b0;
      gain_value    <= GAIN_RST;
      out_sample    <= 16'd0;
      out_valid     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sample_valid) begin
            pipe_sample   <= sample_in;
            dry           <= sample_in;
            bypass_active <= bypass_req;
            gain_value    <= next_gain;
            state         <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          lat_cnt <= LAT_START;
          state   <= (PIPE_LATENCY == 1) ? S_EMIT : S_WAIT;
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) state <= S_EMIT;
        end
        S_EMIT: begin
          out_sample <= bypass_active ? dry : pipe_out;
          out_valid  <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_effects_controller.sv
// tb/tb_effects_controller.sv - randomized self-checking bench for effects_controller
module tb_effects_controller;

  localparam int PL   = 2;
  localparam int STEP = 4;
  localparam int GI   = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_in = 16'd0;
  logic [10:0] gain_target = 11'd0;
  logic        gain_load = 1'b0;
  logic        bypass_req = 1'b0;
  logic [15:0] pipe_out;
  logic [15:0] pipe_sample;
  logic        pipe_en;
  logic [10:0] gain_value;
  logic [15:0] out_sample;
  logic        out_valid;
  logic        busy;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  // reference state
  int          m_gain = GI;
  int          m_target = GI;
  logic        m_overrun = 1'b0;
  logic [15:0] offset = 16'd0;

  // pipeline stub: two-stage delay of pipe_sample plus a bench-controlled offset
  logic [15:0] d1 = 16'd0, d2 = 16'd0;
  always @(posedge clk) begin
    d1 <= pipe_sample;
    d2 <= d1;
  end
  assign pipe_out = d2 + offset;

  always #5 clk = ~clk;

  effects_controller #(.PIPE_LATENCY(PL), .GAIN_STEP(STEP), .GAIN_INIT(GI)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
    .gain_target(gain_target), .gain_load(gain_load), .bypass_req(bypass_req),
    .pipe_out(pipe_out), .pipe_sample(pipe_sample), .pipe_en(pipe_en),
    .gain_value(gain_value), .out_sample(out_sample), .out_valid(out_valid),
    .busy(busy), .overrun(overrun)
  );

  function automatic int slew(input int g, input int t);
    if (t > g) return g + ((t - g) < STEP ? (t - g) : STEP);
    if (t < g) return g - ((g - t) < STEP ? (g - t) : STEP);
    return g;
  endfunction

  task automatic load_gain(input int t);
    gain_target = 11'(t); gain_load = 1'b1;
    @(posedge clk); #1;
    gain_load = 1'b0;
    m_target = t;
  endtask

  // Full sample transaction; optional same-edge gain load and post-capture bypass change
  task automatic do_sample(input logic [15:0] s, input logic bp, input logic bp_after,
                           input logic ld, input int ld_val);
    int k;
    logic [15:0] exp_out;
    sample_in = s; bypass_req = bp; sample_valid = 1'b1;
    if (ld) begin gain_target = 11'(ld_val); gain_load = 1'b1; end
    @(posedge clk); #1;
    sample_valid = 1'b0; gain_load = 1'b0; bypass_req = bp_after;
    m_gain = slew(m_gain, m_target);
    if (ld) m_target = ld_val;
    exp_out = bp ? s : s + offset;
    checks++; if (pipe_en !== 1'b1) begin errors++; $display("FAIL pipe_en: got %b exp 1", pipe_en); end
    checks++; if (pipe_sample !== s) begin errors++; $display("FAIL pipe_sample: got %h exp %h", pipe_sample, s); end
    checks++; if (gain_value !== 11'(m_gain)) begin errors++; $display("FAIL gain_value: got %0d exp %0d", gain_value, m_gain); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy: got %b exp 1", busy); end
    k = 0;
    while (out_valid !== 1'b1 && k < 40) begin @(posedge clk); #1; k++; end
    checks++; if (k !== PL + 1) begin errors++; $display("FAIL latency: got %0d exp %0d", k, PL + 1); end
    checks++; if (out_sample !== exp_out) begin errors++; $display("FAIL out_sample: got %h exp %h", out_sample, exp_out); end
    checks++; if (overrun !== m_overrun) begin errors++; $display("FAIL overrun: got %b exp %b", overrun, m_overrun); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || out_sample !== exp_out || busy !== 1'b0) begin
      errors++; $display("FAIL hold: got v=%b d=%h b=%b exp v=0 d=%h b=0", out_valid, out_sample, busy, exp_out); end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (pipe_sample !== 16'd0 || pipe_en !== 1'b0 || out_sample !== 16'd0 || out_valid !== 1'b0 ||
        busy !== 1'b0 || overrun !== 1'b0 || gain_value !== 11'(GI)) begin
      errors++;
      $display("FAIL %s: got ps=%h en=%b os=%h ov=%b busy=%b or=%b g=%0d exp all zero g=%0d",
               tag, pipe_sample, pipe_en, out_sample, out_valid, busy, overrun, gain_value, GI);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset_state");
    rst = 1'b0;
    m_gain = GI; m_target = GI; m_overrun = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    offset = 16'd0;
    do_sample(16'h1234, 1'b0, 1'b0, 1'b0, 0);
    checks++; if (gain_value !== 11'd64) begin errors++; $display("FAIL basic_gain: got %0d exp 64", gain_value); end
  endtask

  task automatic test_gain_slew;
    int exp_g [5] = '{68, 72, 76, 80, 80};
    load_gain(80);
    checks++; if (gain_value !== 11'(m_gain)) begin errors++; $display("FAIL load_no_change: got %0d exp %0d", gain_value, m_gain); end
    for (int i = 0; i < 5; i++) begin
      offset = 16'($urandom);
      do_sample(16'($urandom), 1'b0, 1'b0, 1'b0, 0);
      checks++; if (gain_value !== 11'(exp_g[i])) begin errors++; $display("FAIL slew_up%0d: got %0d exp %0d", i, gain_value, exp_g[i]); end
    end
    load_gain(77);
    do_sample(16'h0042, 1'b0, 1'b0, 1'b0, 0);
    checks++; if (gain_value !== 11'd77) begin errors++; $display("FAIL slew_no_overshoot: got %0d exp 77", gain_value); end
  endtask

  task automatic test_gain_to_zero;
    int n;
    test_reset();
    load_gain(0);
    n = 0;
    while (gain_value !== 11'd0 && n < 40) begin
      do_sample(16'($urandom), 1'b0, 1'b0, 1'b0, 0);
      n++;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL slew_to_zero_count: got %0d exp 16", n); end
    do_sample(16'h0007, 1'b0, 1'b0, 1'b0, 0);
    checks++; if (gain_value !== 11'd0) begin errors++; $display("FAIL slew_no_wrap: got %0d exp 0", gain_value); end
  endtask

  task automatic test_bypass;
    offset = 16'h0F0F;
    do_sample(16'h8000, 1'b0, 1'b1, 1'b0, 0);
    checks++; if (out_sample !== 16'h8F0F) begin errors++; $display("FAIL bypass_wet: got %h exp 8f0f", out_sample); end
    do_sample(16'h0101, 1'b1, 1'b1, 1'b0, 0);
    checks++; if (out_sample !== 16'h0101) begin errors++; $display("FAIL bypass_dry: got %h exp 0101", out_sample); end
    bypass_req = 1'b0;
  endtask

  task automatic test_same_edge_load;
    int g0;
    g0 = m_gain;
    do_sample(16'h2222, 1'b0, 1'b0, 1'b1, m_gain + 100);
    checks++; if (gain_value !== 11'(g0)) begin errors++; $display("FAIL same_edge_old_target: got %0d exp %0d", gain_value, g0); end
    do_sample(16'h3333, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_overrun;
    int nv;
    logic [10:0] g_before;
    offset = 16'h0011;
    sample_in = 16'hAAAA; bypass_req = 1'b0; sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    m_gain = slew(m_gain, m_target);
    g_before = gain_value;
    @(posedge clk); #1;
    sample_in = 16'h5555; bypass_req = 1'b1; sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0; bypass_req = 1'b0;
    m_overrun = 1'b1;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b exp 1", overrun); end
    checks++; if (pipe_sample !== 16'hAAAA || gain_value !== g_before) begin
      errors++; $display("FAIL overrun_no_change: got ps=%h g=%0d exp ps=aaaa g=%0d", pipe_sample, gain_value, g_before); end
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid === 1'b1) begin
        nv++;
        checks++; if (out_sample !== 16'hAABB) begin errors++; $display("FAIL overrun_out: got %h exp aabb", out_sample); end
      end
      @(posedge clk); #1;
    end
    checks++; if (nv !== 1) begin errors++; $display("FAIL overrun_one_valid: got %0d exp 1", nv); end
    for (int i = 0; i < 3; i++) begin
      offset = 16'($urandom);
      do_sample(16'($urandom), 1'b0, 1'b0, 1'b0, 0);
    end
  endtask

  task automatic test_reset_mid;
    int nv;
    sample_in = 16'h7777; sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    m_gain = GI; m_target = GI; m_overrun = 1'b0;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid === 1'b1) nv++;
      @(posedge clk); #1;
    end
    checks++; if (nv !== 0) begin errors++; $display("FAIL aborted_valid: got %0d exp 0", nv); end
    do_sample(16'h4321, 1'b0, 1'b0, 1'b0, 0);
    checks++; if (gain_value !== 11'(GI)) begin errors++; $display("FAIL post_reset_gain: got %0d exp %0d", gain_value, GI); end
  endtask

  task automatic test_random;
    logic bp, ld;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) load_gain(int'($urandom_range(0, 2047)));
      offset = 16'($urandom);
      bp = 1'($urandom);
      ld = ($urandom_range(0, 4) == 0);
      do_sample(16'($urandom), bp, 1'($urandom), ld, int'($urandom_range(0, 2047)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
    bypass_req = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_gain_slew();
    test_gain_to_zero();
    test_bypass();
    test_same_edge_load();
    test_random();
    test_overrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
